// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings (common to TX and RX), oversampling ratio,
// tick-counter width and the frame parity helper.
package uart_pkg;

    localparam int OVS    = 16;
    localparam int TICK_W = 5;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } uart_state_e;

    // Narrower words are zero-extended, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a first-word-fall-through TX FIFO, paced by a 16x baud tick.
// Optional parity stage enabled by defining UART_TX_PARITY_EN.
module uart_tx_fifo_drain
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PAR_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            fifo_empty,
    input  logic [DBIT-1:0] fifo_r_data,
    output logic            fifo_rd,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam logic [TICK_W-1:0] TICK_ZERO = TICK_W'(0);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVS - 1);
    localparam logic [TICK_W-1:0] STOP_LAST = TICK_W'(SB_TICK - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DBIT - 1);

    uart_state_e       state_r, state_s;
    logic [TICK_W-1:0] tick_r, tick_s;
    logic [2:0]        bit_r, bit_s;
    logic [DBIT-1:0]   shift_r, shift_s;
    logic              tx_r, tx_s;
    logic              done_r, done_s;
    logic              rd_s;
`ifdef UART_TX_PARITY_EN
    logic              par_r, par_s;
`endif

    // Next-state, datapath and line-level computation.
    always_comb begin
        state_s = state_r;
        tick_s  = tick_r;
        bit_s   = bit_r;
        shift_s = shift_r;
        done_s  = 1'b0;
        rd_s    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_s   = par_r;
`endif
        case (state_r)
            IDLE: begin
                if (!fifo_empty) begin
                    rd_s    = 1'b1;
                    shift_s = fifo_r_data;
                    tick_s  = TICK_ZERO;
                    state_s = START;
`ifdef UART_TX_PARITY_EN
                    par_s   = parity_bit(8'(fifo_r_data), 1'(PAR_ODD));
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_r == TICK_LAST) begin
                        tick_s  = TICK_ZERO;
                        bit_s   = 3'd0;
                        state_s = DATA;
                    end else begin
                        tick_s = tick_r + TICK_ONE;
                    end
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_r == TICK_LAST) begin
                        tick_s  = TICK_ZERO;
                        shift_s = {1'b0, shift_r[DBIT-1:1]};
                        if (bit_r == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_s = PARITY;
`else
                            state_s = STOP;
`endif
                        end else begin
                            bit_s = bit_r + 3'd1;
                        end
                    end else begin
                        tick_s = tick_r + TICK_ONE;
                    end
                end else begin
                    state_s = DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (tick_r == TICK_LAST) begin
                        tick_s  = TICK_ZERO;
                        state_s = STOP;
                    end else begin
                        tick_s = tick_r + TICK_ONE;
                    end
                end else begin
                    state_s = PARITY;
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (tick_r == STOP_LAST) begin
                        tick_s  = TICK_ZERO;
                        done_s  = 1'b1;
                        state_s = IDLE;
                    end else begin
                        tick_s = tick_r + TICK_ONE;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
                tick_s  = TICK_ZERO;
                bit_s   = 3'd0;
            end
        endcase

        // Line level follows the state being entered so tx stays a plain register.
        case (state_s)
            IDLE:    tx_s = 1'b1;
            START:   tx_s = 1'b0;
            DATA:    tx_s = shift_s[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_s = par_s;
`endif
            STOP:    tx_s = 1'b1;
            default: tx_s = 1'b1;
        endcase
    end

    // State and datapath registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            tick_r  <= TICK_ZERO;
            bit_r   <= 3'd0;
            shift_r <= {DBIT{1'b0}};
            tx_r    <= 1'b1;
            done_r  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            tick_r  <= tick_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            tx_r    <= tx_s;
            done_r  <= done_s;
`ifdef UART_TX_PARITY_EN
            par_r   <= par_s;
`endif
        end
    end

    assign fifo_rd      = rd_s & reset;
    assign tx           = tx_r;
    assign tx_busy      = (state_r != IDLE);
    assign tx_done_tick = done_r;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed self-checking bench for uart_tx_fifo_drain: FIFO model, 16x tick source and a
// per-tick trace of the line compared against hand-derived frames.
module tb_uart_tx_fifo_drain;

    localparam int DBIT     = 8;
    localparam int SB_TICK  = 16;
    localparam int PAR_ODD  = 0;
`ifdef UART_TX_PARITY_EN
    localparam int PBITS    = 1;
`else
    localparam int PBITS    = 0;
`endif
    localparam int FRAME_TICKS = (1 + DBIT + PBITS) * 16 + SB_TICK;
    localparam int TICK_DIV    = 3;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            s_tick = 1'b0;
    logic            fifo_empty = 1'b1;
    logic [DBIT-1:0] fifo_r_data = '0;
    logic            fifo_rd;
    logic            tx;
    logic            tx_busy;
    logic            tx_done_tick;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo_drain #(.DBIT(DBIT), .SB_TICK(SB_TICK), .PAR_ODD(PAR_ODD)) dut (
        .clk(clk), .reset(reset), .s_tick(s_tick), .fifo_empty(fifo_empty),
        .fifo_r_data(fifo_r_data), .fifo_rd(fifo_rd), .tx(tx), .tx_busy(tx_busy),
        .tx_done_tick(tx_done_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Baud tick: one clk high every TICK_DIV clks, changed just after the edge.
    int div = 0;
    always @(posedge clk) begin
        #1;
        if (div == TICK_DIV - 1) begin
            div = 0;
            s_tick = 1'b1;
        end else begin
            div++;
            s_tick = 1'b0;
        end
    end

    // FWFT FIFO model: a pop seen at the negedge is applied just after the next posedge.
    logic [DBIT-1:0] q[$];
    bit rd_pend = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rd_pend && q.size() > 0) void'(q.pop_front());
        rd_pend = 1'b0;
        fifo_empty = (q.size() == 0);
        fifo_r_data = fifo_empty ? '0 : q[0];
    end

    // Monitor: line level per consumed tick, pops, done pulses, idle gaps, illegal pops.
    logic tr[$];
    int pops = 0, dones = 0, bad_rd = 0, tx_low_idle = 0, idle_run = 0, last_gap = -1;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (fifo_rd) begin
            pops++;
            rd_pend = 1'b1;
            if (tx_busy || fifo_empty) bad_rd++;
        end
        if (tx_done_tick) dones++;
        if (tx_busy && s_tick) tr.push_back(tx);
        if (!tx_busy && tx !== 1'b1) tx_low_idle++;
        if (tx_busy) begin
            if (!prev_busy) last_gap = idle_run;
            idle_run = 0;
        end else begin
            idle_run++;
        end
        prev_busy = tx_busy;
    end

    task automatic clear_mon();
        tr.delete();
        pops = 0;
        dones = 0;
        last_gap = -1;
    endtask

    task automatic wait_dones(input int n, input int limit);
        int c = 0;
        do begin
            @(posedge clk);
            c++;
        end while (dones < n && c < limit);
        #2;
        check("done_timeout", (dones >= n), 1);
    endtask

    function automatic logic exp_sample(input logic [DBIT-1:0] w, input int i);
        if (i < 16) return 1'b0;
        if (i < 16 * (1 + DBIT)) return w[(i - 16) / 16];
`ifdef UART_TX_PARITY_EN
        if (i < 16 * (2 + DBIT)) return (^w) ^ 1'(PAR_ODD);
`endif
        return 1'b1;
    endfunction

    task automatic check_frame(input string tag, input int idx, input logic [DBIT-1:0] w);
        int base = idx * FRAME_TICKS;
        int mism = 0;
        logic [DBIT-1:0] rec = '0;
        check({tag, "_len"}, (tr.size() >= base + FRAME_TICKS), 1);
        if (tr.size() >= base + FRAME_TICKS) begin
            for (int i = 0; i < FRAME_TICKS; i++)
                if (tr[base + i] !== exp_sample(w, i)) mism++;
            for (int b = 0; b < DBIT; b++) rec[b] = tr[base + 16 + 16 * b + 8];
            check({tag, "_data"}, rec, w);
            check({tag, "_mism"}, mism, 0);
        end
    endtask

    initial begin
        logic [9:0] a5_seq;
        int c;
        a5_seq = 10'b1101001010;
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] a5_seq;
        int c;
        a5_seq = 10'b1101001010;

        // Reset held with a word waiting: no pop, line idle.
        repeat (3) @(posedge clk);
        #2;
        q.push_back(8'hA5);
        repeat (4) @(posedge clk);
        #2;
        check("rst_tx", tx, 1);
        check("rst_rd", fifo_rd, 0);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done_tick, 0);
        check("rst_pops", pops, 0);

        // Release: pop in the very first cycle, START on the next edge.
        clear_mon();
        reset = 1'b1;
        #1;
        check("rel_rd", fifo_rd, 1);
        @(posedge clk);
        #2;
        check("start_rd", fifo_rd, 0);
        check("start_tx", tx, 0);
        check("start_busy", tx_busy, 1);
        wait_dones(1, 2000);
        check("a5_ticks", tr.size(), FRAME_TICKS);
        check("a5_pops", pops, 1);
        for (int k = 0; k < 9; k++) begin
            if (tr.size() == FRAME_TICKS)
                check($sformatf("a5_bit%0d", k), tr[16 * k + 8], a5_seq[k]);
        end
        if (tr.size() == FRAME_TICKS) check("a5_stop", tr[FRAME_TICKS - 1], a5_seq[9]);
        check_frame("a5", 0, 8'hA5);
        repeat (5) @(posedge clk);
        #2;
        check("a5_done_once", dones, 1);

        // Back-to-back 0x00 then 0xFF.
        clear_mon();
        q.push_back(8'h00);
        q.push_back(8'hFF);
        wait_dones(2, 4000);
        check("b2b_pops", pops, 2);
        check("b2b_gap", last_gap, 1);
        check("b2b_ticks", tr.size(), 2 * FRAME_TICKS);
        check_frame("b2b0", 0, 8'h00);
        check_frame("b2b1", 1, 8'hFF);
        repeat (3) @(posedge clk);
        #2;
        check("b2b_empty", fifo_empty, 1);
        check("b2b_idle", tx_busy, 0);

        // Empty FIFO for 1000 clk.
        clear_mon();
        repeat (1000) @(posedge clk);
        #2;
        check("idle_pops", pops, 0);
        check("idle_tx", tx, 1);
        check("idle_dones", dones, 0);

        // Reset in the middle of bit 3 of 0x3C.
        clear_mon();
        q.push_back(8'h3C);
        c = 0;
        while (tr.size() < 16 + 3 * 16 + 8 && c < 2000) begin
            @(posedge clk);
            c++;
        end
        #2;
        check("mid_timeout", (tr.size() >= 16 + 3 * 16 + 8), 1);
        check("mid_busy_pre", tx_busy, 1);
        reset = 1'b0;
        #1;
        check("mid_tx", tx, 1);
        check("mid_busy", tx_busy, 0);
        check("mid_rd", fifo_rd, 0);
        q.push_back(8'h5A);
        repeat (3) @(posedge clk);
        #2;
        check("mid_pops", pops, 1);
        check("mid_dones", dones, 0);
        clear_mon();
        reset = 1'b1;
        wait_dones(1, 2000);
        check("post_pops", pops, 1);
        check("post_ticks", tr.size(), FRAME_TICKS);
        check_frame("post", 0, 8'h5A);

        check("bad_rd", bad_rd, 0);
        check("tx_low_idle", tx_low_idle, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
